dispatch_stage: RTL and testbench

//  Parametrised successor to the combinational dispatch decoder: buffers fetched

---
 rtl/dispatch_stage.sv | 187 ++++++++++++++++++
 tb/tb_dispatch_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_stage.sv
// Dispatch stage: instruction FIFO, head decode, ROB tag allocation and
// ready-qualified push into the ALU/AGU/MUL/DIV issue queues.
module dispatch_stage #(
   parameter int DEPTH    = 4,
   parameter int TAG_W    = 5,
   parameter int BR_STALL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_valid,
   input  logic [31:0]      if_icode,
   input  logic [31:0]      if_pc,
   output logic             if_ready,
   input  logic             flush,
   input  logic             rob_ready,
   input  logic             alu_ready,
   input  logic             agu_ready,
   input  logic             mul_ready,
   input  logic             div_ready,
   input  logic             br_resolve,
   output logic             disp_valid,
   output logic [1:0]       disp_unit,
   output logic [2:0]       disp_alu_ext,
   output logic             disp_ls,
   output logic             disp_reg_w,
   output logic             disp_jmp,
   output logic             disp_jmp_reg,
   output logic             disp_branch,
   output logic [1:0]       disp_op1_sel,
   output logic             disp_op2_sel,
   output logic [31:0]      disp_icode,
   output logic [31:0]      disp_pc,
   output logic [TAG_W-1:0] disp_tag,
   output logic             br_pending,
   output logic             illegal
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {UNIT_ALU = 2'd0, UNIT_AGU = 2'd1, UNIT_MUL = 2'd2, UNIT_DIV = 2'd3} unit_t;
   typedef enum logic [2:0] {
      EXT_NORMAL = 3'd0, EXT_JAL = 3'd1, EXT_JALR = 3'd2,
      EXT_BRANCH = 3'd3, EXT_ALT = 3'd4, EXT_ADD  = 3'd5
   } ext_t;
   typedef enum logic [1:0] {OP1_ZERO = 2'd0, OP1_RS1 = 2'd1, OP1_PC = 2'd2} op1_t;

   typedef struct packed {
      logic [31:0] icode;
      logic [31:0] pc;
   } entry_t;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [PTR_W:0]   count;
   logic [TAG_W-1:0] tag;

   entry_t   head;
   logic     head_valid, push, pop, fire, legal, unit_ready;
   unit_t    unit;
   ext_t     ext;
   op1_t     op1;
   logic     ls, reg_w, jmp, jmp_reg, branch, op2;
   logic [6:0] opcode, f7;
   logic [2:0] f3;

   assign head       = mem[rd_ptr];
   assign head_valid = (count != '0);
   assign if_ready   = (count != FULL_CNT);
   assign opcode     = head.icode[6:0];
   assign f3         = head.icode[14:12];
   assign f7         = head.icode[31:25];

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      legal   = 1'b1;
      unit    = UNIT_ALU;
      ext     = EXT_NORMAL;
      op1     = OP1_ZERO;
      op2     = 1'b0;
      ls      = 1'b0;
      reg_w   = 1'b0;
      jmp     = 1'b0;
      jmp_reg = 1'b0;
      branch  = 1'b0;
      unique case (opcode)
         7'b0110011: begin
            op1   = OP1_RS1;
            op2   = 1'b1;
            reg_w = 1'b1;
            if (f7 == 7'h01) unit = f3[2] ? UNIT_DIV : UNIT_MUL;
            else             ext  = (f7 == 7'h20) ? EXT_ALT : EXT_NORMAL;
         end
         7'b0010011: begin
            op1   = OP1_RS1;
            reg_w = 1'b1;
            ext   = (f7 == 7'h20) ? EXT_ALT : EXT_NORMAL;
         end
         7'b0110111: begin ext = EXT_ADD; reg_w = 1'b1; end
         7'b0010111: begin ext = EXT_ADD; op1 = OP1_PC; reg_w = 1'b1; end
         7'b0000011: begin unit = UNIT_AGU; op1 = OP1_RS1; reg_w = 1'b1; end
         7'b0100011: begin unit = UNIT_AGU; ls = 1'b1; op1 = OP1_RS1; op2 = 1'b1; end
         7'b1100011: begin ext = EXT_BRANCH; op1 = OP1_RS1; op2 = 1'b1; branch = 1'b1; end
         7'b1101111: begin ext = EXT_JAL; op1 = OP1_PC; op2 = 1'b1; jmp = 1'b1; reg_w = 1'b1; end
         7'b1100111: begin
            ext     = EXT_JALR;
            op1     = OP1_RS1;
            jmp     = 1'b1;
            jmp_reg = 1'b1;
            reg_w   = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      unique case (unit)
         UNIT_ALU: unit_ready = alu_ready;
         UNIT_AGU: unit_ready = agu_ready;
         UNIT_MUL: unit_ready = mul_ready;
         default:  unit_ready = div_ready;
      endcase
   end

   // Illegal heads are dropped regardless of downstream readiness or a pending branch.
   assign fire    = head_valid & legal & ~br_pending & rob_ready & unit_ready & ~flush;
   assign illegal = head_valid & ~legal & ~flush;
   assign pop     = fire | illegal;
   assign push    = if_valid & if_ready & ~flush;

   assign disp_valid   = fire;
   assign disp_unit    = unit;
   assign disp_alu_ext = ext;
   assign disp_ls      = ls;
   assign disp_reg_w   = reg_w;
   assign disp_jmp     = jmp;
   assign disp_jmp_reg = jmp_reg;
   assign disp_branch  = branch;
   assign disp_op1_sel = op1;
   assign disp_op2_sel = op2;
   assign disp_icode   = head.icode;
   assign disp_pc      = head.pc;
   assign disp_tag     = tag;

   // NOTE: FIFO storage has no reset; count alone decides validity, so stale entries are never observed.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{icode: if_icode, pc: if_pc};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + (PTR_W+1)'(1);
         else if (pop && !push) count <= count - (PTR_W+1)'(1);
      end
   end

   // The tag survives flush: the ROB owns recovery of allocated tags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    tag <= '0;
      else if (fire) tag <= tag + TAG_W'(1);
   end

   generate
      if (BR_STALL != 0) begin : g_br_stall
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                     br_pending <= 1'b0;
            else if (flush)                 br_pending <= 1'b0;
            else if (fire && (branch | jmp)) br_pending <= 1'b1;
            else if (br_resolve)            br_pending <= 1'b0;
         end
      end else begin : g_no_stall
         assign br_pending = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed bench for dispatch_stage: reset, per-unit dispatch, back-pressure,
// branch stall, illegal drop, tag wrap, flush and mid-run reset.
module tb_dispatch_stage;

   localparam int DEPTH = 4;
   localparam int TAG_W = 5;

   localparam logic [31:0] ADD  = 32'h00B50533;
   localparam logic [31:0] MUL  = 32'h02B50533;
   localparam logic [31:0] ADDI = 32'h00150513;
   localparam logic [31:0] BEQ  = 32'h00B50463;
   localparam logic [31:0] JAL  = 32'h0000006F;
   localparam logic [31:0] BAD  = 32'h0000007F;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             if_valid, if_ready, flush;
   logic [31:0]      if_icode, if_pc;
   logic             rob_ready, alu_ready, agu_ready, mul_ready, div_ready, br_resolve;
   logic             disp_valid, disp_ls, disp_reg_w, disp_jmp, disp_jmp_reg, disp_branch;
   logic [1:0]       disp_unit, disp_op1_sel;
   logic [2:0]       disp_alu_ext;
   logic             disp_op2_sel;
   logic [31:0]      disp_icode, disp_pc;
   logic [TAG_W-1:0] disp_tag;
   logic             br_pending, illegal;

   int vectors    = 0;
   int miscompares = 0;

   dispatch_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W), .BR_STALL(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_valid(if_valid), .if_icode(if_icode), .if_pc(if_pc), .if_ready(if_ready),
      .flush(flush), .rob_ready(rob_ready),
      .alu_ready(alu_ready), .agu_ready(agu_ready), .mul_ready(mul_ready), .div_ready(div_ready),
      .br_resolve(br_resolve),
      .disp_valid(disp_valid), .disp_unit(disp_unit), .disp_alu_ext(disp_alu_ext),
      .disp_ls(disp_ls), .disp_reg_w(disp_reg_w), .disp_jmp(disp_jmp),
      .disp_jmp_reg(disp_jmp_reg), .disp_branch(disp_branch),
      .disp_op1_sel(disp_op1_sel), .disp_op2_sel(disp_op2_sel),
      .disp_icode(disp_icode), .disp_pc(disp_pc), .disp_tag(disp_tag),
      .br_pending(br_pending), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ready(input logic r);
      rob_ready = r; alu_ready = r; agu_ready = r; mul_ready = r; div_ready = r;
   endtask

   task automatic offer(input logic [31:0] icode, input logic [31:0] pc);
      if_valid = 1'b1; if_icode = icode; if_pc = pc;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; if_valid = 1'b0; if_icode = '0; if_pc = '0;
      flush = 1'b0; br_resolve = 1'b0; set_ready(1'b1);
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({if_ready, disp_valid, illegal, br_pending, disp_tag} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0}) begin
         miscompares++;
         $display("FAIL reset_state: got rdy/val/ill/bp/tag=%b%b%b%b/%0d want 1000/0",
                  if_ready, disp_valid, illegal, br_pending, disp_tag);
      end
      @(negedge clk) rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_add();
      set_ready(1'b1);
      offer(ADD, 32'h100);
      #1;
      vectors++;
      if (disp_valid !== 1'b0) begin
         miscompares++; $display("FAIL add_no_bypass: got disp_valid=%b want 0", disp_valid);
      end
      cyc();
      if_valid = 1'b0;
      #1;
      vectors++;
      if ({disp_valid, disp_unit, disp_alu_ext, disp_reg_w, disp_op1_sel, disp_op2_sel, disp_tag, disp_pc}
          !== {1'b1, 2'd0, 3'd0, 1'b1, 2'd1, 1'b1, 5'd0, 32'h100}) begin
         miscompares++;
         $display("FAIL add_dispatch: got v=%b u=%0d e=%0d w=%b o1=%0d o2=%b tag=%0d pc=%h want 1 0 0 1 1 1 0 100",
                  disp_valid, disp_unit, disp_alu_ext, disp_reg_w, disp_op1_sel, disp_op2_sel, disp_tag, disp_pc);
      end
      cyc();
      vectors++;
      if (disp_valid !== 1'b0) begin
         miscompares++; $display("FAIL add_single_fire: got disp_valid=%b want 0", disp_valid);
      end
   endtask

   task automatic test_mul_ready();
      set_ready(1'b1);
      mul_ready = 1'b0;
      offer(MUL, 32'h104);
      cyc();
      if_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if (disp_valid !== 1'b0) begin
            miscompares++; $display("FAIL mul_blocked[%0d]: got disp_valid=%b want 0", i, disp_valid);
         end
         cyc();
      end
      mul_ready = 1'b1;
      #1;
      vectors++;
      if ({disp_valid, disp_unit, disp_reg_w, disp_tag} !== {1'b1, 2'd2, 1'b1, 5'd1}) begin
         miscompares++;
         $display("FAIL mul_dispatch: got v=%b u=%0d w=%b tag=%0d want 1 2 1 1",
                  disp_valid, disp_unit, disp_reg_w, disp_tag);
      end
      cyc();
   endtask

   task automatic test_full();
      set_ready(1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         offer(ADDI, 32'h200 + 32'(4 * i));
         #1;
         vectors++;
         if (if_ready !== 1'b1) begin
            miscompares++; $display("FAIL fill_ready[%0d]: got if_ready=%b want 1", i, if_ready);
         end
         cyc();
      end
      offer(ADDI, 32'h200 + 32'(4 * DEPTH));
      for (int i = 0; i < 2; i++) begin
         #1;
         vectors++;
         if ({if_ready, disp_valid} !== 2'b00) begin
            miscompares++; $display("FAIL full_hold[%0d]: got if_ready/disp_valid=%b%b want 00", i, if_ready, disp_valid);
         end
         cyc();
      end
      set_ready(1'b1);
      for (int k = 0; k <= DEPTH; k++) begin
         #1;
         vectors++;
         if ({disp_valid, disp_op2_sel, disp_pc, disp_tag} !== {1'b1, 1'b0, 32'h200 + 32'(4 * k), 5'(2 + k)}) begin
            miscompares++;
            $display("FAIL drain[%0d]: got v=%b o2=%b pc=%h tag=%0d want 1 0 %h %0d",
                     k, disp_valid, disp_op2_sel, disp_pc, disp_tag, 32'h200 + 32'(4 * k), 2 + k);
         end
         if (k < 2) begin
            vectors++;
            if (if_ready !== (k == 1)) begin
               miscompares++; $display("FAIL drain_ready[%0d]: got if_ready=%b want %b", k, if_ready, (k == 1));
            end
         end
         cyc();
         if (k == 1) if_valid = 1'b0;
      end
   endtask

   task automatic test_branch_stall();
      set_ready(1'b1);
      offer(BEQ, 32'h300);
      cyc();
      offer(ADD, 32'h304);
      #1;
      vectors++;
      if ({disp_valid, disp_unit, disp_alu_ext, disp_branch, disp_jmp, disp_reg_w, disp_op1_sel, disp_op2_sel, disp_tag}
          !== {1'b1, 2'd0, 3'd3, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 5'd7}) begin
         miscompares++;
         $display("FAIL beq_dispatch: got v=%b u=%0d e=%0d br=%b j=%b w=%b o1=%0d o2=%b tag=%0d want 1 0 3 1 0 0 1 1 7",
                  disp_valid, disp_unit, disp_alu_ext, disp_branch, disp_jmp, disp_reg_w,
                  disp_op1_sel, disp_op2_sel, disp_tag);
      end
      cyc();
      if_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         vectors++;
         if ({br_pending, disp_valid} !== 2'b10) begin
            miscompares++; $display("FAIL br_hold[%0d]: got br_pending/disp_valid=%b%b want 10", i, br_pending, disp_valid);
         end
         cyc();
      end
      br_resolve = 1'b1;
      #1;
      vectors++;
      if (disp_valid !== 1'b0) begin
         miscompares++; $display("FAIL br_resolve_cycle: got disp_valid=%b want 0", disp_valid);
      end
      cyc();
      br_resolve = 1'b0;
      #1;
      vectors++;
      if ({br_pending, disp_valid, disp_pc, disp_tag} !== {1'b0, 1'b1, 32'h304, 5'd8}) begin
         miscompares++;
         $display("FAIL br_release: got bp=%b v=%b pc=%h tag=%0d want 0 1 304 8", br_pending, disp_valid, disp_pc, disp_tag);
      end
      cyc();
   endtask

   task automatic test_illegal();
      set_ready(1'b1);
      offer(BAD, 32'h400);
      cyc();
      offer(ADD, 32'h404);
      set_ready(1'b0);
      #1;
      vectors++;
      if ({illegal, disp_valid} !== 2'b10) begin
         miscompares++; $display("FAIL illegal_pulse: got illegal/disp_valid=%b%b want 10", illegal, disp_valid);
      end
      cyc();
      if_valid = 1'b0;
      set_ready(1'b1);
      #1;
      vectors++;
      if ({illegal, disp_valid, disp_tag, disp_pc} !== {1'b0, 1'b1, 5'd9, 32'h404}) begin
         miscompares++;
         $display("FAIL illegal_next: got ill=%b v=%b tag=%0d pc=%h want 0 1 9 404", illegal, disp_valid, disp_tag, disp_pc);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      logic [TAG_W-1:0] exp_tag;
      exp_tag = 5'd10;
      set_ready(1'b1);
      offer(ADD, 32'h800);
      cyc();
      for (int i = 0; i < 23; i++) begin
         if (i == 22) if_valid = 1'b0;
         else         if_pc = 32'h804 + 32'(4 * i);
         #1;
         vectors++;
         if ({disp_valid, disp_tag} !== {1'b1, exp_tag}) begin
            miscompares++;
            $display("FAIL b2b_tag[%0d]: got v=%b tag=%0d want 1 %0d", i, disp_valid, disp_tag, exp_tag);
         end
         cyc();
         exp_tag = exp_tag + 5'd1;
      end
   endtask

   task automatic test_flush();
      set_ready(1'b1);
      offer(JAL, 32'h500);
      cyc();
      offer(ADD, 32'h504);
      #1;
      vectors++;
      if ({disp_valid, disp_alu_ext, disp_jmp, disp_jmp_reg, disp_reg_w, disp_op1_sel, disp_op2_sel, disp_tag}
          !== {1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 5'd1}) begin
         miscompares++;
         $display("FAIL jal_dispatch: got v=%b e=%0d j=%b jr=%b w=%b o1=%0d o2=%b tag=%0d want 1 1 1 0 1 2 1 1",
                  disp_valid, disp_alu_ext, disp_jmp, disp_jmp_reg, disp_reg_w, disp_op1_sel, disp_op2_sel, disp_tag);
      end
      cyc();
      if_pc = 32'h508;
      cyc();
      if_pc = 32'h50C;
      cyc();
      if_pc = 32'h510;
      flush = 1'b1;
      #1;
      vectors++;
      if ({br_pending, disp_valid, illegal} !== 3'b100) begin
         miscompares++;
         $display("FAIL flush_cycle: got bp/v/ill=%b%b%b want 100", br_pending, disp_valid, illegal);
      end
      cyc();
      flush = 1'b0;
      if_valid = 1'b0;
      #1;
      vectors++;
      if ({if_ready, br_pending, disp_valid} !== 3'b100) begin
         miscompares++;
         $display("FAIL flush_empty: got rdy/bp/v=%b%b%b want 100", if_ready, br_pending, disp_valid);
      end
      cyc();
      offer(ADD, 32'h600);
      cyc();
      if_valid = 1'b0;
      #1;
      vectors++;
      if ({disp_valid, disp_pc, disp_tag} !== {1'b1, 32'h600, 5'd2}) begin
         miscompares++;
         $display("FAIL flush_tag_kept: got v=%b pc=%h tag=%0d want 1 600 2", disp_valid, disp_pc, disp_tag);
      end
      cyc();
   endtask

   task automatic test_reset_mid();
      set_ready(1'b0);
      offer(ADD, 32'h700);
      cyc();
      if_pc = 32'h704;
      cyc();
      if_valid = 1'b0;
      set_ready(1'b1);
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({if_ready, disp_valid, br_pending, disp_tag} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
         miscompares++;
         $display("FAIL reset_mid: got rdy/v/bp/tag=%b%b%b/%0d want 100/0", if_ready, disp_valid, br_pending, disp_tag);
      end
      @(negedge clk) rst_n = 1'b1;
      cyc();
      offer(ADD, 32'h708);
      cyc();
      if_valid = 1'b0;
      #1;
      vectors++;
      if ({disp_valid, disp_pc, disp_tag} !== {1'b1, 32'h708, 5'd0}) begin
         miscompares++;
         $display("FAIL reset_mid_resume: got v=%b pc=%h tag=%0d want 1 708 0", disp_valid, disp_pc, disp_tag);
      end
      cyc();
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul_ready();
      test_full();
      test_branch_stall();
      test_illegal();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
